store_queue: RTL and testbench
==============================

// Module: store_queue
// PURPOSE
//  Buffered, parametrised register-to-memory store path. Accepts LANES-wide lane-masked stores
//  over a valid/ready handshake and queues them in a DEPTH-entry FIFO. Serialises each entry into
//  MEM_LANES-wide beats on the memory/cache write port, skipping beats with an all-zero mask.
//  Sits between the register file write-back lanes and the memory/cache interface.
// PARAMETERS
//  DATA_W     NSIG+1          bits per lane; multiple of 8
//  LANES      REGLD_PER_CLK   lanes per store request
//  MEM_LANES  4               lanes per memory beat; LANES % MEM_LANES == 0
//  DEPTH      4               FIFO entries; power of 2, >= 2
//  ADDR_W     32              byte address width
// PORTS
//  clk         in   1                 clock
//  rst_n       in   1                 synchronous active-low reset
//  st_valid_i  in   1                 store request valid
//  st_ready_o  out  1                 queue can accept
//  st_addr_i   in   ADDR_W            byte address of lane 0
//  st_data_i   in   DATA_W x LANES    lane data
//  st_mask_i   in   LANES             lane write enables
//  mem_valid_o out  1                 beat valid
//  mem_ready_i in   1                 memory accepts beat
//  mem_addr_o  out  ADDR_W            beat byte address
//  mem_data_o  out  DATA_W x MEM_LANES  beat data
//  mem_mask_o  out  MEM_LANES         beat lane enables
//  idle_o      out  1                 FIFO empty and no beat in flight
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): FIFO emptied, FSM->IDLE, mem_valid_o=0, mem_addr/data/mask=0,
//    st_ready_o=1, idle_o=1. Reset mid-burst discards all queued and partially sent entries.
//  - Push on st_valid_i&&st_ready_o. st_ready_o = !full. No push-through when full, even if a pop
//    occurs in the same cycle.
//  - Entry with st_mask_i==0 is accepted and popped without emitting any beat.
//  - Beat b (0..LANES/MEM_LANES-1) carries lanes [b*MEM_LANES +: MEM_LANES].
//    mem_addr_o = base + b*MEM_LANES*DATA_W/8, modulo 2^ADDR_W (wrap, no error).
//  - FSM IDLE: if FIFO non-empty, select first beat with non-zero mask and go to SEND; else stay.
//  - FSM SEND: mem_valid_o=1. mem_addr/data/mask are registered and stable until mem_ready_i.
//    On handshake, advance to next non-zero beat. After last non-zero beat, pop entry, then load
//    next head (back-to-back, no bubble) or go to IDLE.
//  - Latency: store pushed into an empty queue in cycle N presents its first beat at cycle N+1.
//  - Simultaneous push and pop are both honoured; count unchanged.
//  - mem_valid_o never drops without a handshake, except at reset.
//  - idle_o = FIFO empty && FSM==IDLE.
// CONFIGURATION
//  STORE_QUEUE_STATS_EN defined: adds outputs stat_stores_o[31:0] and stat_stall_o[31:0].
//    stat_stores_o counts accepted pushes; stat_stall_o counts cycles with
//    mem_valid_o && !mem_ready_i. Both saturate at 2^32-1 and clear on reset.
//  Macro undefined: these ports and counters do not exist; functional behaviour is identical.
// STRUCTURE
//  - In package OpCodes: NSIG, REGLD_PER_CLK, store_entry_t {addr, data[REGLD_PER_CLK], mask},
//    and enum sq_state_e {SQ_IDLE, SQ_SEND}.
//  - Sub-module store_fifo: synchronous first-word-fall-through FIFO with DEPTH entries.
//    Ports: push, pop, full, empty, head; pointers one bit wider than log2(DEPTH).
//  - Top level: FSM, beat index, next-non-zero-beat priority search, output registers.
// TESTING  (DATA_W=16, LANES=8, MEM_LANES=4, DEPTH=4)
//  1. One store, addr 0x100, mask 0xFF, mem_ready_i=1 -> beats at 0x100 mask 0xF and 0x108 mask 0xF
//     on consecutive cycles, the first beat 1 cycle after push; then idle_o=1.
//  2. Mask 0xF0 at 0x200 -> exactly one beat: addr 0x208, lanes 4-7, mask 0xF.
//     Mask 0x00 -> no beat; entry popped.
//  3. Hold mem_ready_i=0, push 4 stores -> st_ready_o=0 after the 4th push; payload stable.
//     Release mem_ready_i -> 8 beats in order, no bubbles.
//  4. Addr 0xFFFFFFFC, mask 0xFF -> second beat addr 0x00000004 (wrap).
//  5. Assert rst_n=0 during beat 2 of 3 queued stores -> next cycle mem_valid_o=0, idle_o=1;
//     no stale beats after release.
//  6. STORE_QUEUE_STATS_EN: case 3 -> stat_stores_o=4, stat_stall_o equals the held cycles.

Source files
------------

// File: rtl/store_queue_pkg.sv
// Shared types for the register-to-memory store path: default lane geometry,
// the queued store payload and the beat-sequencer state encoding.
package OpCodes;

  localparam int unsigned NSIG          = 15;
  localparam int unsigned REGLD_PER_CLK = 8;
  localparam int unsigned SQ_ADDR_W     = 32;

  // Field order matches the flattened entry {addr, data, mask} held in the FIFO
  typedef struct packed {
    logic [SQ_ADDR_W-1:0]              addr;
    logic [REGLD_PER_CLK-1:0][NSIG:0]  data;
    logic [REGLD_PER_CLK-1:0]          mask;
  } store_entry_t;

  typedef enum logic [0:0] {
    SQ_IDLE = 1'b0,
    SQ_SEND = 1'b1
  } sq_state_e;

endpackage

// File: rtl/store_queue_fifo.sv
// First-word-fall-through FIFO holding flattened store entries; also exposes
// the entry behind the head so the sequencer can chain entries without a bubble.
module store_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic             multi,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] head2
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    rd_idx2;
  logic [WIDTH-1:0] mem [DEPTH];

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign multi   = (count > (AW+1)'(1));
  assign rd_idx  = rd_ptr[AW-1:0];
  assign rd_idx2 = rd_idx + AW'(1);
  assign head    = mem[rd_idx];
  assign head2   = mem[rd_idx2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: pointers alone define validity
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/store_queue.sv
// Lane-masked store queue: buffers stores and serialises them into memory beats.
// Optional STORE_QUEUE_STATS_EN adds push and stall counters.
module store_queue
  import OpCodes::*;
#(
  parameter int unsigned DATA_W    = NSIG + 1,
  parameter int unsigned LANES     = REGLD_PER_CLK,
  parameter int unsigned MEM_LANES = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 st_valid_i,
  output logic                                 st_ready_o,
  input  logic [ADDR_W-1:0]                    st_addr_i,
  input  logic [LANES-1:0][DATA_W-1:0]         st_data_i,
  input  logic [LANES-1:0]                     st_mask_i,
  output logic                                 mem_valid_o,
  input  logic                                 mem_ready_i,
  output logic [ADDR_W-1:0]                    mem_addr_o,
  output logic [MEM_LANES-1:0][DATA_W-1:0]     mem_data_o,
  output logic [MEM_LANES-1:0]                 mem_mask_o,
  output logic                                 idle_o
`ifdef STORE_QUEUE_STATS_EN
  ,
  output logic [31:0]                          stat_stores_o,
  output logic [31:0]                          stat_stall_o
`endif
);

  localparam int unsigned NB         = LANES / MEM_LANES;
  localparam int unsigned BIW        = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned BEAT_BYTES = MEM_LANES * DATA_W / 8;
  localparam int unsigned EW         = ADDR_W + LANES * DATA_W + LANES;

  typedef logic [LANES-1:0][DATA_W-1:0] lane_data_t;

  sq_state_e                    state, state_nxt;
  logic [BIW-1:0]               beat_idx, beat_nxt;
  logic                         valid_nxt;
  logic [ADDR_W-1:0]            addr_nxt;
  logic [MEM_LANES-1:0][DATA_W-1:0] data_nxt;
  logic [MEM_LANES-1:0]         mask_nxt;

  logic                         full, empty, multi, push, pop;
  logic [EW-1:0]                st_entry, head, head2, fresh;
  lane_data_t                   head_data, fresh_data;
  logic [ADDR_W-1:0]            head_addr, fresh_addr;
  logic [LANES-1:0]             head_mask, fresh_mask;
  logic                         cur_hit, fresh_hit, load_cur, load_fresh;
  logic [BIW-1:0]               cur_idx, fresh_idx;

  // Lowest beat at or above start whose lane mask is non-zero
  function automatic logic [BIW:0] find_beat(input logic [LANES-1:0] m,
                                             input int unsigned start);
    logic           found;
    logic [BIW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (!found && b >= start && m[b*MEM_LANES +: MEM_LANES] != '0) begin
        found = 1'b1;
        idx   = BIW'(b);
      end
    end
    return {found, idx};
  endfunction

  assign st_entry   = {st_addr_i, st_data_i, st_mask_i};
  assign push       = st_valid_i && !full;
  assign st_ready_o = !full;
  assign idle_o     = empty && (state == SQ_IDLE);

  store_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (st_entry),
    .full  (full),
    .empty (empty),
    .multi (multi),
    .head  (head),
    .head2 (head2)
  );

  // Next entry to start: bypass the input when nothing is queued ahead of it
  assign fresh = (state == SQ_IDLE) ? (empty ? st_entry : head)
                                    : (multi ? head2 : st_entry);

  assign head_addr  = head[EW-1 -: ADDR_W];
  assign head_data  = head[LANES +: LANES*DATA_W];
  assign head_mask  = head[LANES-1:0];
  assign fresh_addr = fresh[EW-1 -: ADDR_W];
  assign fresh_data = fresh[LANES +: LANES*DATA_W];
  assign fresh_mask = fresh[LANES-1:0];

  assign {cur_hit, cur_idx}     = find_beat(head_mask, 32'(beat_idx) + 32'd1);
  assign {fresh_hit, fresh_idx} = find_beat(fresh_mask, 32'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SQ_IDLE;
      beat_idx    <= '0;
      mem_valid_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_mask_o  <= '0;
    end else begin
      state       <= state_nxt;
      beat_idx    <= beat_nxt;
      mem_valid_o <= valid_nxt;
      mem_addr_o  <= addr_nxt;
      mem_data_o  <= data_nxt;
      mem_mask_o  <= mask_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat_idx;
    valid_nxt  = mem_valid_o;
    addr_nxt   = mem_addr_o;
    data_nxt   = mem_data_o;
    mask_nxt   = mem_mask_o;
    pop        = 1'b0;
    load_cur   = 1'b0;
    load_fresh = 1'b0;
    case (state)
      SQ_IDLE: begin
        // A queued all-zero-mask entry is retired without emitting a beat
        if (!empty || push) begin
          if (fresh_hit) load_fresh = 1'b1;
          else           pop        = !empty;
        end
      end
      SQ_SEND: begin
        if (mem_ready_i) begin
          if (cur_hit) begin
            load_cur = 1'b1;
          end else begin
            pop = 1'b1;
            if ((multi || push) && fresh_hit) begin
              load_fresh = 1'b1;
            end else begin
              state_nxt = SQ_IDLE;
              valid_nxt = 1'b0;
            end
          end
        end
      end
      default: state_nxt = SQ_IDLE;
    endcase
    if (load_cur) begin
      beat_nxt = cur_idx;
      addr_nxt = head_addr + ADDR_W'(BEAT_BYTES * 32'(cur_idx));
      data_nxt = head_data[cur_idx*MEM_LANES +: MEM_LANES];
      mask_nxt = head_mask[cur_idx*MEM_LANES +: MEM_LANES];
    end
    if (load_fresh) begin
      state_nxt = SQ_SEND;
      valid_nxt = 1'b1;
      beat_nxt  = fresh_idx;
      addr_nxt  = fresh_addr + ADDR_W'(BEAT_BYTES * 32'(fresh_idx));
      data_nxt  = fresh_data[fresh_idx*MEM_LANES +: MEM_LANES];
      mask_nxt  = fresh_mask[fresh_idx*MEM_LANES +: MEM_LANES];
    end
  end

`ifdef STORE_QUEUE_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_stores_o <= '0;
      stat_stall_o  <= '0;
    end else begin
      if (push && stat_stores_o != '1) stat_stores_o <= stat_stores_o + 32'd1;
      if (mem_valid_o && !mem_ready_i && stat_stall_o != '1)
        stat_stall_o <= stat_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_store_queue.sv
// Randomised and directed bench for store_queue with a beat-level scoreboard.
// Checks the statistics outputs too when STORE_QUEUE_STATS_EN is defined.
module tb_store_queue;
  import OpCodes::*;

  localparam int unsigned DATA_W = 16, LANES = 8, MEM_LANES = 4, DEPTH = 4, ADDR_W = 32;

  logic                              clk = 1'b0;
  logic                              rst_n = 1'b0;
  logic                              st_valid = 1'b0;
  logic                              st_ready;
  logic [ADDR_W-1:0]                 st_addr = '0;
  logic [LANES-1:0][DATA_W-1:0]      st_data = '0;
  logic [LANES-1:0]                  st_mask = '0;
  logic                              mem_valid;
  logic                              mem_ready = 1'b0;
  logic [ADDR_W-1:0]                 mem_addr;
  logic [MEM_LANES-1:0][DATA_W-1:0]  mem_data;
  logic [MEM_LANES-1:0]              mem_mask;
  logic                              idle;
`ifdef STORE_QUEUE_STATS_EN
  logic [31:0]                       stat_stores;
  logic [31:0]                       stat_stall;
`endif

  store_queue #(.DATA_W(DATA_W), .LANES(LANES), .MEM_LANES(MEM_LANES),
                .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid_i  (st_valid),
    .st_ready_o  (st_ready),
    .st_addr_i   (st_addr),
    .st_data_i   (st_data),
    .st_mask_i   (st_mask),
    .mem_valid_o (mem_valid),
    .mem_ready_i (mem_ready),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .mem_mask_o  (mem_mask),
    .idle_o      (idle)
`ifdef STORE_QUEUE_STATS_EN
    ,
    .stat_stores_o (stat_stores),
    .stat_stall_o  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [3:0]  mask;
  } beat_t;

  beat_t       exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          beats_seen = 0;
  int          stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [99:0] prev_payload = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: a store expands into one beat per non-empty group of MEM_LANES lanes
  function automatic void add_store(input store_entry_t e);
    for (int b = 0; b < 2; b++) begin
      logic [3:0]       m;
      logic [3:0][15:0] d;
      m = e.mask[b*4 +: 4];
      d = e.data[b*4 +: 4];
      if (m != 4'h0) exp_q.push_back('{addr: e.addr + 32'(b * 8), data: d, mask: m});
    end
  endfunction

  // Scoreboard and handshake-rule monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
      stall_cnt  = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(mem_valid), 64'd1);
        check("hold_payload", 64'({mem_addr, mem_mask} ^ prev_payload[99:64]) |
              (64'(mem_data) ^ prev_payload[63:0]), 64'd0);
      end
      if (mem_valid && !mem_ready) stall_cnt++;
      if (mem_valid && mem_ready) begin
        beats_seen++;
        check("beat_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_addr", 64'(mem_addr), 64'(e.addr));
          check("beat_mask", 64'(mem_mask), 64'(e.mask));
          check("beat_data", 64'(mem_data), e.data);
        end
      end
      prev_stall   = mem_valid && !mem_ready;
      prev_payload = {mem_addr, mem_mask, 64'(mem_data)};
      if (st_valid && st_ready) begin
        store_entry_t s;
        s.addr = st_addr;
        s.data = st_data;
        s.mask = st_mask;
        add_store(s);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [7:0] m);
    st_valid = 1'b1;
    st_addr  = a;
    st_mask  = m;
    st_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic apply_reset();
    cyc();
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    mem_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen0;
    int waited;

    apply_reset();
    @(negedge clk);
    check("rst_valid", 64'(mem_valid), 64'd0);
    check("rst_ready", 64'(st_ready), 64'd1);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_addr_mask", 64'({mem_addr, mem_mask}), 64'd0);

    // Single full store: two consecutive beats, first one cycle after the push
    cyc();
    mem_ready = 1'b1;
    drive_store(32'h100, 8'hFF);
    cyc();
    st_valid = 1'b0;
    @(negedge clk);
    check("t1_b0_valid", 64'(mem_valid), 64'd1);
    check("t1_b0_addr", 64'(mem_addr), 64'h100);
    check("t1_b0_mask", 64'(mem_mask), 64'hF);
    cyc();
    @(negedge clk);
    check("t1_b1_valid", 64'(mem_valid), 64'd1);
    check("t1_b1_addr", 64'(mem_addr), 64'h108);
    cyc();
    @(negedge clk);
    check("t1_done_valid", 64'(mem_valid), 64'd0);
    check("t1_idle", 64'(idle), 64'd1);

    // Upper-half mask: single beat at the second beat address
    drive_store(32'h200, 8'hF0);
    cyc();
    st_valid = 1'b0;
    @(negedge clk);
    check("t2_addr", 64'(mem_addr), 64'h208);
    check("t2_mask", 64'(mem_mask), 64'hF);
    cyc();
    @(negedge clk);
    check("t2_single", 64'(mem_valid), 64'd0);

    // Empty mask: accepted, never emits a beat, queue drains
    seen0 = beats_seen;
    drive_store(32'h300, 8'h00);
    cyc();
    st_valid = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    check("t2_zero_beats", 64'(beats_seen - seen0), 64'd0);
    check("t2_zero_idle", 64'(idle), 64'd1);

    // Backpressure: four stores fill the queue, then eight gap-free beats
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h1000 + 32'(i * 16), 8'hFF);
      @(negedge clk);
      check("t3_ready_pre", 64'(st_ready), 64'd1);
      cyc();
    end
    st_valid = 1'b0;
    @(negedge clk);
    check("t3_full", 64'(st_ready), 64'd0);
    cyc();
    cyc();
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t3_no_bubble", 64'(mem_valid), 64'd1);
      cyc();
    end
    @(negedge clk);
    check("t3_drained", 64'(idle), 64'd1);
    check("t3_sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef STORE_QUEUE_STATS_EN
    check("t6_stores", 64'(stat_stores), 64'd4);
    check("t6_stall", 64'(stat_stall), 64'(stall_cnt));
`endif

    // Address wrap on the second beat
    drive_store(32'hFFFF_FFFC, 8'hFF);
    cyc();
    st_valid = 1'b0;
    @(negedge clk);
    check("t4_b0_addr", 64'(mem_addr), 64'hFFFF_FFFC);
    cyc();
    @(negedge clk);
    check("t4_wrap_addr", 64'(mem_addr), 64'h4);
    cyc();

    // Reset in the middle of a burst discards everything queued
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h4000 + 32'(i * 16), 8'hFF);
      cyc();
    end
    st_valid  = 1'b0;
    mem_ready = 1'b1;
    cyc();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_valid", 64'(mem_valid), 64'd0);
    check("t5_idle", 64'(idle), 64'd1);
    seen0 = beats_seen;
    mem_ready = 1'b1;
    repeat (10) cyc();
    @(negedge clk);
    check("t5_no_stale", 64'(beats_seen - seen0), 64'd0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 800; i++) begin
      cyc();
      mem_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 2) != 0) begin
        logic [31:0] a;
        logic [7:0]  m;
        a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                        : $urandom;
        case ($urandom_range(0, 4))
          0:       m = 8'h00;
          1:       m = 8'hFF;
          2:       m = 8'(1 << $urandom_range(0, 7));
          default: m = 8'($urandom);
        endcase
        drive_store(a, m);
      end else begin
        st_valid = 1'b0;
      end
    end
    cyc();
    st_valid  = 1'b0;
    mem_ready = 1'b1;
    waited = 0;
    while (!(idle && exp_q.size() == 0) && waited < 200) begin
      cyc();
      waited++;
    end
    @(negedge clk);
    check("rand_drain_done", 64'(waited < 200), 64'd1);
    check("rand_sb_empty", 64'(exp_q.size()), 64'd0);
    check("rand_idle", 64'(idle), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
